// File: rtl/ps2_pkg.sv
// Shared scan-code constants, event word layout and parser state encoding
// for the PS/2 set-2 key decoder.
package ps2_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_ERR_LO = 8'h00;
  localparam logic [7:0] SC_ERR_HI = 8'hFF;

  localparam int EV_W        = 13;
  localparam int EV_CODE_LSB = 0;
  localparam int EV_EXT_BIT  = 8;
  localparam int EV_BRK_BIT  = 9;
  localparam int EV_MODS_LSB = 10;

  // mods = {caps_lock, ctrl, shift}
  typedef struct packed {
    logic [2:0] mods;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } ev_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

endpackage

// File: rtl/ps2_event_fifo.sv
// Synchronous event FIFO; output word is zero while empty.
// A push while full only succeeds when a pop happens in the same cycle.
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = EV_W
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 decoder: byte latched at edge k, event queued at k+1, visible the cycle after.
// Intake is one byte per two cycles; a full queue drops events and flags err_overflow.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int CNT_W         = 8,
  parameter int FIFO_DEPTH    = 8,
  parameter bit REPEAT_FILTER = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [7:0]       ps2_byte,
  input  logic             ps2_ready,
  input  logic             ps2_overflow,
  output logic             ps2_nextdata_n,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [7:0]       ev_code,
  output logic             ev_ext,
  output logic             ev_break,
  output logic [2:0]       ev_mods,
  output logic             shift,
  output logic             ctrl,
  output logic             caps_lock,
  output logic             key_down,
  output logic [7:0]       cur_code,
  output logic [CNT_W-1:0] press_count,
  input  logic             err_clr,
  output logic             err_overflow,
  output logic             err_code
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  logic [7:0]   byte_q;
  logic         byte_vld;
  parse_state_t state, state_nxt;
  logic         evt, bad_code, cur_ext, cur_brk;
  logic         lshift, rshift, lctrl, rctrl;
  logic         lshift_nxt, rshift_nxt, lctrl_nxt, rctrl_nxt, caps_nxt;
  logic [8:0]   key, held_key;
  logic         is_ls, is_rs, is_lc, is_rc, is_caps, is_mod, is_rep, drop_rep;
  logic         push, pop, full, empty, drop;
  ev_t          ev_in, ev_head;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ps2_nextdata_n <= 1'b1;
      byte_vld       <= 1'b0;
      byte_q         <= '0;
    end else if (ps2_nextdata_n && ps2_ready) begin
      ps2_nextdata_n <= 1'b0;
      byte_vld       <= 1'b1;
      byte_q         <= ps2_byte;
    end else begin
      ps2_nextdata_n <= 1'b1;
      byte_vld       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    evt       = 1'b0;
    bad_code  = 1'b0;
    cur_ext   = (state == ST_EXT) || (state == ST_EXT_BRK);
    cur_brk   = (state == ST_BRK) || (state == ST_EXT_BRK);
    if (byte_vld) begin
      if (byte_q == SC_EXT) begin
        state_nxt = ST_EXT;
      end else if (byte_q == SC_BRK) begin
        state_nxt = cur_ext ? ST_EXT_BRK : ST_BRK;
      end else if (byte_q == SC_ERR_LO || byte_q == SC_ERR_HI) begin
        bad_code  = 1'b1;
        state_nxt = ST_IDLE;
      end else begin
        evt       = 1'b1;
        state_nxt = ST_IDLE;
      end
    end
  end

  assign key      = {cur_ext, byte_q};
  assign is_ls    = evt && key == {1'b0, SC_LSHIFT};
  assign is_rs    = evt && key == {1'b0, SC_RSHIFT};
  assign is_lc    = evt && key == {1'b0, SC_CTRL};
  assign is_rc    = evt && key == {1'b1, SC_CTRL};
  assign is_caps  = evt && key == {1'b0, SC_CAPS};
  assign is_mod   = is_ls || is_rs || is_lc || is_rc || is_caps;
  assign is_rep   = evt && !is_mod && !cur_brk && key_down && (held_key == key);
  assign drop_rep = is_rep && REPEAT_FILTER;

  assign lshift_nxt = is_ls ? !cur_brk : lshift;
  assign rshift_nxt = is_rs ? !cur_brk : rshift;
  assign lctrl_nxt  = is_lc ? !cur_brk : lctrl;
  assign rctrl_nxt  = is_rc ? !cur_brk : rctrl;
  assign caps_nxt   = (is_caps && !cur_brk && !drop_rep) ? !caps_lock : caps_lock;

  // Event carries the modifier state as it stands after this event's own update.
  always_comb begin
    ev_in      = '0;
    ev_in.mods = {caps_nxt, lctrl_nxt | rctrl_nxt, lshift_nxt | rshift_nxt};
    ev_in.brk  = cur_brk;
    ev_in.ext  = cur_ext;
    ev_in.code = byte_q;
  end

  assign push = evt && !drop_rep;
  assign pop  = !empty && ev_ready;
  assign drop = push && full && !pop;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      lshift      <= 1'b0;
      rshift      <= 1'b0;
      lctrl       <= 1'b0;
      rctrl       <= 1'b0;
      caps_lock   <= 1'b0;
      key_down    <= 1'b0;
      held_key    <= '0;
      cur_code    <= '0;
      press_count <= '0;
    end else begin
      lshift    <= lshift_nxt;
      rshift    <= rshift_nxt;
      lctrl     <= lctrl_nxt;
      rctrl     <= rctrl_nxt;
      caps_lock <= caps_nxt;
      if (evt && !is_mod) begin
        if (!cur_brk) begin
          if (!is_rep) begin
            held_key <= key;
            cur_code <= byte_q;
            key_down <= 1'b1;
          end
        end else begin
          if (held_key == key) key_down <= 1'b0;
          press_count <= press_count + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      err_overflow <= 1'b0;
      err_code     <= 1'b0;
    end else begin
      if (ps2_overflow || drop) err_overflow <= 1'b1;
      else if (err_clr)         err_overflow <= 1'b0;
      if (bad_code)             err_code     <= 1'b1;
      else if (err_clr)         err_code     <= 1'b0;
    end
  end

  ps2_event_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(EV_W)) u_fifo (
    .clk   (clk),
    .clrn  (clrn),
    .push  (push),
    .wdata (ev_in),
    .pop   (pop),
    .rdata (ev_head),
    .full  (full),
    .empty (empty)
  );

  assign ev_valid = !empty;
  assign ev_code  = ev_head.code;
  assign ev_ext   = ev_head.ext;
  assign ev_break = ev_head.brk;
  assign ev_mods  = ev_head.mods;
  assign shift    = lshift | rshift;
  assign ctrl     = lctrl | rctrl;

endmodule
